// File: rtl/sdram_types.sv
// Shared types for the SDRAM request arbiter.
// Holds the arbiter FSM encoding and the default read-outstanding cap.
package sdram_types;

   localparam int SDRAM_MAX_OUTS = 4;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_ISSUE = 1'b1
   } arb_state_t;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin grant selection for the SDRAM arbiter.
// With SDRAM_ARB_PRIO0_EN defined, client 0 always wins when eligible.
module sdram_rr_pick #(
   parameter int IN = 2
) (
   input  logic [2**IN-1:0] elig,
   input  logic [IN-1:0]    last_grant,
   output logic [IN-1:0]    grant,
   output logic             valid
);

   logic [2**IN-1:0] cand;
   logic [IN-1:0]    idx;

   // first candidate after last_grant, wrapping modulo the client count
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      cand  = elig;
`ifdef SDRAM_ARB_PRIO0_EN
      cand[0] = 1'b0;
`endif
      for (int i = 1; i <= 2**IN; i++) begin
         idx = last_grant + IN'(i);
         if (!valid && cand[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
`ifdef SDRAM_ARB_PRIO0_EN
      if (elig[0]) begin
         grant = '0;
         valid = 1'b1;
      end
`endif
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Multi-client SDRAM request arbiter with per-client read credit tracking.
// Optional SDRAM_ARB_PRIO0_EN gives client 0 strict priority.
module sdram_arbiter
   import sdram_types::*;
#(
   parameter int AN       = 24,
   parameter int DN       = 16,
   parameter int IN       = 2,
   parameter int MAX_OUTS = SDRAM_MAX_OUTS
) (
   input  logic                  clkSYS,
   input  logic                  reset,
   input  logic [2**IN-1:0]      cl_req,
   input  logic [2**IN-1:0]      cl_wr,
   input  logic [(2**IN)*AN-1:0] cl_addr,
   input  logic [(2**IN)*DN-1:0] cl_data,
   output logic [2**IN-1:0]      cl_ack,
   output logic [DN-1:0]         cl_rdata,
   output logic [2**IN-1:0]      cl_rvalid,
   output logic [AN-1:0]         req_addr,
   output logic [DN-1:0]         req_data,
   output logic [IN-1:0]         req_id,
   output logic                  req,
   output logic                  req_wr,
   input  logic                  req_ack,
   input  logic [DN-1:0]         mem_data,
   input  logic [IN-1:0]         mem_id,
   input  logic                  mem_valid,
   output logic                  rd_err
);

   localparam int N = 2**IN;

   arb_state_t    state;
   logic [IN-1:0] last_grant;
   logic [IN-1:0] pick_id;
   logic          pick_vld;
   logic [N-1:0]  elig;
   logic [N-1:0]  inc_v;
   logic [N-1:0]  dec_v;
   logic [3:0]    outs [N];
   logic          acc_rd;

   assign acc_rd = (state == ARB_ISSUE) && req_ack && !req_wr;

   // writes are always eligible; reads only while credit remains
   always_comb begin
      elig  = '0;
      inc_v = '0;
      dec_v = '0;
      for (int k = 0; k < N; k++) begin
         elig[k]  = cl_req[k] && (cl_wr[k] || (outs[k] < 4'(MAX_OUTS)));
         inc_v[k] = acc_rd && (req_id == IN'(k));
         dec_v[k] = mem_valid && (mem_id == IN'(k));
      end
   end

   sdram_rr_pick #(
      .IN(IN)
   ) u_pick (
      .elig      (elig),
      .last_grant(last_grant),
      .grant     (pick_id),
      .valid     (pick_vld)
   );

   // two-state issue FSM: capture a client in IDLE, hold it until accepted
   always_ff @(posedge clkSYS or posedge reset) begin
      if (reset) begin
         state      <= ARB_IDLE;
         req        <= 1'b0;
         req_wr     <= 1'b0;
         req_addr   <= '0;
         req_data   <= '0;
         req_id     <= '0;
         cl_ack     <= '0;
         last_grant <= IN'(N - 1);
      end else begin
         cl_ack <= '0;
         unique case (state)
            ARB_IDLE: begin
               if (pick_vld) begin
                  req_addr <= cl_addr[pick_id*AN +: AN];
                  req_data <= cl_data[pick_id*DN +: DN];
                  req_wr   <= cl_wr[pick_id];
                  req_id   <= pick_id;
                  req      <= 1'b1;
                  cl_ack   <= N'(1) << pick_id;
                  state    <= ARB_ISSUE;
               end else begin
                  req <= 1'b0;
               end
            end
            ARB_ISSUE: begin
               if (req_ack) begin
                  req        <= 1'b0;
                  last_grant <= req_id;
                  state      <= ARB_IDLE;
               end
            end
         endcase
      end
   end

   // outstanding read credits; an unmatched return flags a sticky error
   always_ff @(posedge clkSYS or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N; k++) outs[k] <= '0;
         rd_err <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (inc_v[k] && !dec_v[k]) begin
               outs[k] <= outs[k] + 4'd1;
            end else if (dec_v[k] && !inc_v[k]) begin
               if (outs[k] == 4'd0) rd_err <= 1'b1;
               else outs[k] <= outs[k] - 4'd1;
            end
         end
      end
   end

   // read return path, one register stage
   always_ff @(posedge clkSYS or posedge reset) begin
      if (reset) begin
         cl_rdata  <= '0;
         cl_rvalid <= '0;
      end else begin
         cl_rdata  <= mem_data;
         cl_rvalid <= mem_valid ? (N'(1) << mem_id) : '0;
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed cases plus random traffic
// checked against a transaction-level arbitration model.
module tb_sdram_arbiter;

   localparam int AN = 24;
   localparam int DN = 16;
   localparam int IN = 2;
   localparam int N  = 4;
   localparam int MO = 4;

   logic            clkSYS = 1'b0;
   logic            reset;
   logic [N-1:0]    cl_req, cl_wr, cl_ack, cl_rvalid;
   logic [N*AN-1:0] cl_addr;
   logic [N*DN-1:0] cl_data;
   logic [DN-1:0]   cl_rdata, req_data, mem_data;
   logic [AN-1:0]   req_addr;
   logic [IN-1:0]   req_id, mem_id;
   logic            req, req_wr, req_ack, mem_valid, rd_err;

   sdram_arbiter #(.AN(AN), .DN(DN), .IN(IN), .MAX_OUTS(MO)) dut (
      .clkSYS(clkSYS), .reset(reset),
      .cl_req(cl_req), .cl_wr(cl_wr), .cl_addr(cl_addr), .cl_data(cl_data),
      .cl_ack(cl_ack), .cl_rdata(cl_rdata), .cl_rvalid(cl_rvalid),
      .req_addr(req_addr), .req_data(req_data), .req_id(req_id),
      .req(req), .req_wr(req_wr), .req_ack(req_ack),
      .mem_data(mem_data), .mem_id(mem_id), .mem_valid(mem_valid),
      .rd_err(rd_err)
   );

   always #5 clkSYS = ~clkSYS;

   typedef struct {logic [N-1:0] oh; logic [DN-1:0] d; int due;} ret_t;
   typedef struct {int id; int cyc;} ack_t;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   ret_t sbq[$];
   ack_t alog[$];

   logic [N-1:0] hold;
   int           pend[N];
   bit           rnd;

   bit            m_busy, m_wr, m_err;
   int            m_last, m_id;
   logic [AN-1:0] m_addr;
   logic [DN-1:0] m_data;
   int            m_outs[N];

   logic [N-1:0]    s_req = '0, s_wr = '0;
   logic [N*AN-1:0] s_addr = '0;
   logic [N*DN-1:0] s_data = '0;
   logic            s_ack = 1'b0, s_mv = 1'b0;
   logic [IN-1:0]   s_mid = '0;

   always @(posedge clkSYS) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [127:0] a, logic [127:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endfunction

   function automatic int pick(logic [N-1:0] e, int last);
`ifdef SDRAM_ARB_PRIO0_EN
      if (e[0]) return 0;
      for (int i = 1; i <= N; i++) begin
         int c;
         c = (last + i) % N;
         if (c != 0 && e[c]) return c;
      end
`else
      for (int i = 1; i <= N; i++) begin
         int c;
         c = (last + i) % N;
         if (e[c]) return c;
      end
`endif
      return -1;
   endfunction

   always @(negedge clkSYS) begin : mon
      logic [N-1:0] e;
      int   g, acc_id;
      bit   acc;
      ret_t it;
      if (reset) begin
         m_busy = 0; m_last = N - 1; m_err = 0;
         foreach (m_outs[k]) m_outs[k] = 0;
         sbq.delete();
         chk("reset_state", {req, req_wr, req_addr, req_data, req_id,
             cl_ack, cl_rvalid, cl_rdata, rd_err}, '0);
      end else begin
         acc = 0; acc_id = 0;
         if (!m_busy) begin
            for (int k = 0; k < N; k++)
               e[k] = s_req[k] && (s_wr[k] || m_outs[k] < MO);
            g = pick(e, m_last);
            if (g >= 0) begin
               chk("grant", cl_ack, N'(1) << g);
               m_busy = 1; m_id = g; m_wr = s_wr[g];
               m_addr = s_addr[g*AN +: AN];
               m_data = s_data[g*DN +: DN];
               alog.push_back('{g, cyc});
            end else begin
               chk("no_grant", cl_ack, 0);
            end
         end else begin
            chk("ack_busy", cl_ack, 0);
            if (s_ack) begin
               m_busy = 0; m_last = m_id;
               if (!m_wr) begin acc = 1; acc_id = m_id; end
            end
         end
         if (acc && !(s_mv && int'(s_mid) == acc_id)) m_outs[acc_id]++;
         if (s_mv && !(acc && int'(s_mid) == acc_id)) begin
            if (m_outs[s_mid] == 0) m_err = 1;
            else m_outs[s_mid]--;
         end
         chk("req", req, m_busy);
         if (m_busy)
            chk("req_bundle", {req_id, req_wr, req_addr, req_data},
                {IN'(m_id), m_wr, m_addr, m_data});
         chk("rd_err", rd_err, m_err);
         if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            it = sbq.pop_front();
            chk("rvalid", cl_rvalid, it.oh);
            chk("rdata", cl_rdata, it.d);
         end else begin
            chk("rvalid_idle", cl_rvalid, 0);
         end
      end
      s_req = cl_req; s_wr = cl_wr; s_addr = cl_addr; s_data = cl_data;
      s_ack = req_ack; s_mv = mem_valid; s_mid = mem_id;
   end

   task automatic new_txn(int k);
      cl_addr[k*AN +: AN] = AN'($urandom);
      cl_data[k*DN +: DN] = DN'($urandom);
   endtask

   task automatic ret(int k, logic [DN-1:0] d);
      mem_valid = 1'b1;
      mem_id    = IN'(k);
      mem_data  = d;
      if (pend[k] > 0) pend[k]--;
      sbq.push_back('{N'(1) << k, d, cyc + 1});
   endtask

   task automatic step();
      bit r_req, r_ack, r_wr;
      logic [IN-1:0] r_id;
      r_req = req; r_ack = req_ack; r_wr = req_wr; r_id = req_id;
      @(posedge clkSYS); #1;
      if (!reset && r_req && r_ack && !r_wr) pend[r_id]++;
      mem_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (cl_req[k] && cl_ack[k]) begin
            if (hold[k]) new_txn(k);
            else cl_req[k] = 1'b0;
            if (rnd) hold[k] = ($urandom_range(0, 1) == 0);
         end
      end
      if (rnd) begin
         for (int k = 0; k < N; k++) begin
            if (!cl_req[k] && $urandom_range(0, 9) < 3) begin
               cl_req[k] = 1'b1;
               cl_wr[k]  = ($urandom_range(0, 2) == 0);
               hold[k]   = ($urandom_range(0, 3) == 0);
               new_txn(k);
            end
         end
         req_ack = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 9) < 4) begin
            int k;
            k = $urandom_range(0, N - 1);
            if (pend[k] > 0) ret(k, DN'($urandom));
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cl_req = '0; hold = '0; req_ack = 1'b0; mem_valid = 1'b0;
      step(); step();
      reset = 1'b0;
      foreach (pend[k]) pend[k] = 0;
   endtask

   initial begin
      logic [AN-1:0] a3;
      int cnt;
      bit ok;
      reset = 1'b1; rnd = 0; hold = '0;
      cl_req = '0; cl_wr = '0; cl_addr = '0; cl_data = '0;
      req_ack = 1'b0; mem_valid = 1'b0; mem_id = '0; mem_data = '0;
      foreach (pend[k]) pend[k] = 0;
      repeat (3) step();
      reset = 1'b0;

      // three simultaneous readers, immediate accept
      alog.delete();
      for (int k = 0; k < 3; k++) new_txn(k);
      cl_req = 4'b0111; req_ack = 1'b1;
      repeat (8) step();
      chk("ord_cnt", alog.size(), 3);
      if (alog.size() == 3) begin
         for (int i = 0; i < 3; i++) chk("ord_id", alog[i].id, i);
         chk("ack_gap01", alog[1].cyc - alog[0].cyc, 2);
         chk("ack_gap12", alog[2].cyc - alog[1].cyc, 2);
      end
      for (int k = 0; k < 3; k++) begin ret(k, DN'($urandom)); step(); end

      // stalled controller holds the request stable
      req_ack = 1'b0;
      new_txn(3); cl_req[3] = 1'b1;
      a3 = cl_addr[3*AN +: AN];
      step();
      repeat (5) begin
         step();
         chk("hold_req", {req, req_id, req_addr}, {1'b1, 2'd3, a3});
      end
      req_ack = 1'b1;
      step();
      chk("req_drop", req, 1'b0);
      ret(3, DN'($urandom)); step();

      // read credit cap
      do_reset();
      alog.delete();
      hold[1] = 1'b1; new_txn(1); cl_req[1] = 1'b1; req_ack = 1'b1;
      repeat (14) step();
      chk("cap_cnt", alog.size(), 4);
      ret(1, DN'($urandom)); step();
      repeat (3) step();
      chk("cap_regrant", alog.size(), 5);
      hold[1] = 1'b0; cl_req[1] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (pend[1] > 0) ret(1, DN'($urandom));
         step();
      end
      chk("rd_err_cap", rd_err, 1'b0);

      // return data path and credit decrement
      do_reset();
      new_txn(2); cl_req[2] = 1'b1; req_ack = 1'b1;
      repeat (3) step();
      ret(2, 16'hBEEF); step();
      chk("rv_2", cl_rvalid, 4'b0100);
      chk("rd_beef", cl_rdata, 16'hBEEF);
      chk("no_err_2", rd_err, 1'b0);
      ret(2, 16'h0001); step();
      chk("err_after_dec", rd_err, 1'b1);

      // unmatched return is sticky until reset
      do_reset();
      ret(0, 16'h1234); step();
      chk("err_set", rd_err, 1'b1);
      repeat (3) step();
      chk("err_sticky", rd_err, 1'b1);
      do_reset();
      chk("err_clear", rd_err, 1'b0);

      // reset while a request is pending drops it
      new_txn(3); cl_req[3] = 1'b1; req_ack = 1'b0;
      step(); step();
      chk("pend_req", req, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      foreach (pend[k]) pend[k] = 0;
      repeat (3) begin
         step();
         chk("no_reissue", {req, cl_ack}, 0);
      end

      // clients 0 and 3 requesting continuously
      do_reset();
      alog.delete();
      cl_wr[0] = 1'b1; cl_wr[3] = 1'b1; hold = 4'b1001;
      new_txn(0); new_txn(3);
      cl_req = 4'b1001; req_ack = 1'b1;
      repeat (16) step();
      chk("pair_cnt", alog.size(), 8);
      ok = 1;
      foreach (alog[i]) begin
`ifdef SDRAM_ARB_PRIO0_EN
         if (alog[i].id != 0) ok = 0;
`else
         if (alog[i].id != ((i % 2) ? 3 : 0)) ok = 0;
`endif
      end
      chk("pair_seq", ok, 1'b1);
      hold = '0; cl_req = '0; cl_wr = '0;

      // random traffic
      do_reset();
      rnd = 1;
      repeat (3000) step();
      rnd = 0; cl_req = '0; hold = '0; req_ack = 1'b1;
      for (int i = 0; i < 60; i++) begin
         cnt = 0;
         for (int k = 0; k < N; k++) begin
            if (cnt == 0 && pend[k] > 0) begin
               ret(k, DN'($urandom)); cnt = 1;
            end
         end
         step();
      end
      repeat (3) step();
      chk("sb_empty", sbq.size(), 0);
      chk("rd_err_end", rd_err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
